// File: rtl/alu_issue.sv
// alu_issue: single-entry execute-issue register with operand select and writeback forwarding.
module alu_issue #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      f3_i,
  input  logic [6:0]      f7_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [SIZE-1:0] rs1_data_i,
  input  logic [SIZE-1:0] rs2_data_i,
  input  logic [SIZE-1:0] imm_i,
  input  logic [SIZE-1:0] pc_i,
  input  logic [1:0]      op1_sel_i,
  input  logic            op2_sel_i,
  input  logic [4:0]      rd_i,
  input  logic            rd_we_i,
  input  logic            fwd_valid_i,
  input  logic [4:0]      fwd_rd_i,
  input  logic [SIZE-1:0] fwd_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2:0]      f3_o,
  output logic [6:0]      f7_o,
  output logic [SIZE-1:0] op1_o,
  output logic [SIZE-1:0] op2_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o
);
  logic [4:0] rs1_q, rs2_q;
  logic reg1_q, reg2_q;
  logic capture, fwd1, fwd2, hit1, hit2;
  logic [SIZE-1:0] rs1_val, rs2_val, op1_nxt, op2_nxt;
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign capture = in_valid_i && in_ready_o && !flush_i;
  assign fwd1 = fwd_valid_i && fwd_rd_i == rs1_addr_i && rs1_addr_i != 5'd0;
  assign fwd2 = fwd_valid_i && fwd_rd_i == rs2_addr_i && rs2_addr_i != 5'd0;
  assign rs1_val = fwd1 ? fwd_data_i : rs1_data_i;
  assign rs2_val = fwd2 ? fwd_data_i : rs2_data_i;
  assign op1_nxt = op1_sel_i == 2'b00 ? rs1_val : op1_sel_i == 2'b01 ? pc_i : '0;
  assign op2_nxt = op2_sel_i ? imm_i : rs2_val;
  // held operands only snoop if they came from the register file
  assign hit1 = reg1_q && fwd_valid_i && fwd_rd_i == rs1_q && rs1_q != 5'd0;
  assign hit2 = reg2_q && fwd_valid_i && fwd_rd_i == rs2_q && rs2_q != 5'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_o <= 1'b0;
      f3_o <= '0;
      f7_o <= '0;
      op1_o <= '0;
      op2_o <= '0;
      rd_o <= '0;
      rd_we_o <= 1'b0;
      rs1_q <= '0;
      rs2_q <= '0;
      reg1_q <= 1'b0;
      reg2_q <= 1'b0;
    end else begin
      out_valid_o <= !flush_i && (capture || (out_valid_o && !out_ready_i));
      if (capture) begin
        f3_o <= f3_i;
        f7_o <= (op2_sel_i && f3_i != 3'b101) ? 7'd0 : f7_i;
        op1_o <= op1_nxt;
        op2_o <= op2_nxt;
        rd_o <= rd_i;
        rd_we_o <= rd_we_i;
        rs1_q <= rs1_addr_i;
        rs2_q <= rs2_addr_i;
        reg1_q <= op1_sel_i == 2'b00;
        reg2_q <= !op2_sel_i;
      end else if (out_valid_o) begin
        if (hit1) op1_o <= fwd_data_i;
        if (hit2) op2_o <= fwd_data_i;
      end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized and directed scoreboard bench for alu_issue at SIZE=4.
module tb_alu_issue;
  localparam int W = 4;
  logic clk = 0, rst = 1;
  logic in_valid_i = 0, in_ready_o;
  logic [2:0] f3_i = 0;
  logic [6:0] f7_i = 0;
  logic [4:0] rs1_addr_i = 0, rs2_addr_i = 0, rd_i = 0, fwd_rd_i = 0;
  logic [W-1:0] rs1_data_i = 0, rs2_data_i = 0, imm_i = 0, pc_i = 0, fwd_data_i = 0;
  logic [1:0] op1_sel_i = 0;
  logic op2_sel_i = 0, rd_we_i = 0, fwd_valid_i = 0, flush_i = 0, out_ready_i = 1;
  logic out_valid_o, rd_we_o;
  logic [2:0] f3_o;
  logic [6:0] f7_o;
  logic [W-1:0] op1_o, op2_o;
  logic [4:0] rd_o;

  alu_issue #(.SIZE(W)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .f3_i(f3_i), .f7_i(f7_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .pc_i(pc_i),
    .op1_sel_i(op1_sel_i), .op2_sel_i(op2_sel_i), .rd_i(rd_i), .rd_we_i(rd_we_i),
    .fwd_valid_i(fwd_valid_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .f3_o(f3_o), .f7_o(f7_o), .op1_o(op1_o), .op2_o(op2_o), .rd_o(rd_o), .rd_we_o(rd_we_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] f3;
    logic [6:0] f7;
    logic [W-1:0] op1, op2;
    logic [4:0] rd, a1, a2;
    logic we, r1, r2;
  } entry_t;

  entry_t q[$];
  int vectors = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic entry_t expect_of_inputs();
    entry_t e;
    logic [W-1:0] v1, v2;
    v1 = (fwd_valid_i && fwd_rd_i == rs1_addr_i && rs1_addr_i != 0) ? fwd_data_i : rs1_data_i;
    v2 = (fwd_valid_i && fwd_rd_i == rs2_addr_i && rs2_addr_i != 0) ? fwd_data_i : rs2_data_i;
    e.f3 = f3_i;
    e.f7 = (op2_sel_i && f3_i != 3'b101) ? 7'd0 : f7_i;
    e.op1 = (op1_sel_i == 0) ? v1 : (op1_sel_i == 1) ? pc_i : '0;
    e.op2 = op2_sel_i ? imm_i : v2;
    e.rd = rd_i;
    e.we = rd_we_i;
    e.a1 = rs1_addr_i;
    e.a2 = rs2_addr_i;
    e.r1 = op1_sel_i == 0;
    e.r2 = !op2_sel_i;
    return e;
  endfunction

  // Scoreboard: check the held entry each cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      automatic bit full = q.size() != 0;
      check("in_ready", in_ready_o, !full || out_ready_i);
      check("out_valid", out_valid_o, full);
      if (full) begin
        check("f3", f3_o, q[0].f3);
        check("f7", f7_o, q[0].f7);
        check("op1", op1_o, q[0].op1);
        check("op2", op2_o, q[0].op2);
        check("rd", rd_o, q[0].rd);
        check("rd_we", rd_we_o, q[0].we);
      end
      if (flush_i) q.delete();
      else begin
        automatic bit cap = in_valid_i && (!full || out_ready_i);
        if (full && out_ready_i) void'(q.pop_front());
        else if (full && fwd_valid_i) begin
          if (q[0].r1 && q[0].a1 != 0 && q[0].a1 == fwd_rd_i) q[0].op1 = fwd_data_i;
          if (q[0].r2 && q[0].a2 != 0 && q[0].a2 == fwd_rd_i) q[0].op2 = fwd_data_i;
        end
        if (cap) q.push_back(expect_of_inputs());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] a1,
                       input logic [W-1:0] d1, input logic [4:0] a2, input logic [W-1:0] d2,
                       input logic [1:0] s1, input logic s2, input logic [W-1:0] imm);
    in_valid_i = 1; f3_i = f3; f7_i = f7;
    rs1_addr_i = a1; rs1_data_i = d1; rs2_addr_i = a2; rs2_data_i = d2;
    op1_sel_i = s1; op2_sel_i = s2; imm_i = imm;
    pc_i = W'($urandom); rd_i = 5'($urandom); rd_we_i = 1'($urandom);
  endtask

  task automatic randomize_inputs();
    in_valid_i = 1'($urandom);
    f3_i = 3'($urandom); f7_i = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom);
    rs1_addr_i = 5'($urandom_range(0, 3)); rs2_addr_i = 5'($urandom_range(0, 3));
    rs1_data_i = W'($urandom); rs2_data_i = W'($urandom);
    imm_i = W'($urandom); pc_i = W'($urandom);
    op1_sel_i = 2'($urandom); op2_sel_i = 1'($urandom);
    rd_i = 5'($urandom); rd_we_i = 1'($urandom);
    fwd_valid_i = 1'($urandom); fwd_rd_i = 5'($urandom_range(0, 3)); fwd_data_i = W'($urandom);
    flush_i = $urandom_range(0, 15) == 0;
    out_ready_i = $urandom_range(0, 2) != 0;
  endtask

  initial begin
    int sent;
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_ready", in_ready_o, 1);
    check("rst_ops", {op1_o, op2_o, f3_o, f7_o, rd_o, rd_we_o}, 0);
    step();
    rst = 0;
    step();
    instr(3'b000, 7'h20, 5'd1, 4'b1111, 5'd2, 4'b1000, 2'b00, 1'b0, 4'd0);
    step();
    check("sub_op1", op1_o, 4'b1111);
    check("sub_op2", op2_o, 4'b1000);
    check("sub_f7", f7_o, 7'h20);
    check("sub_valid", out_valid_o, 1);
    instr(3'b000, 7'h20, 5'd1, 4'd0, 5'd2, 4'd0, 2'b00, 1'b1, 4'b0110);
    step();
    check("addi_f7", f7_o, 7'd0);
    check("addi_op2", op2_o, 4'b0110);
    instr(3'b101, 7'h20, 5'd1, 4'd0, 5'd2, 4'd0, 2'b00, 1'b1, 4'b0110);
    step();
    check("srai_f7", f7_o, 7'h20);
    instr(3'b000, 7'h00, 5'd3, 4'd0, 5'd0, 4'd0, 2'b00, 1'b1, 4'd2);
    fwd_valid_i = 1; fwd_rd_i = 3; fwd_data_i = 4'b0111;
    step();
    check("fwd_cap", op1_o, 4'b0111);
    in_valid_i = 0; out_ready_i = 0; fwd_data_i = 4'b0001;
    #1 check("stall_ready", in_ready_o, 0);
    step();
    check("fwd_hold", op1_o, 4'b0001);
    out_ready_i = 1; in_valid_i = 1;
    rs1_addr_i = 0; rs1_data_i = 4'd9; fwd_rd_i = 0; fwd_data_i = 4'd5;
    step();
    check("fwd_x0_cap", op1_o, 4'd9);
    in_valid_i = 0; out_ready_i = 0;
    step();
    check("fwd_x0_hold", op1_o, 4'd9);
    fwd_valid_i = 0; in_valid_i = 1; rd_i = 5'd17; out_ready_i = 1; flush_i = 1;
    step();
    check("flush_valid", out_valid_o, 0);
    flush_i = 0; in_valid_i = 0;
    step();
    check("flush_drop", out_valid_o, 0);
    sent = 0;
    for (int c = 0; c < 60 && sent < 10; c++) begin
      instr(3'($urandom), 7'($urandom), 5'd1, W'($urandom), 5'd2, W'($urandom), 2'b00, 1'b0, 4'd0);
      rd_i = 5'(sent);
      out_ready_i = (c % 3) != 1;
      #1 if (in_ready_o) sent++;
      step();
    end
    check("b2b_sent", sent, 10);
    in_valid_i = 0; out_ready_i = 1;
    step(); step();
    instr(3'd1, 7'd1, 5'd1, 4'd3, 5'd2, 4'd4, 2'b00, 1'b0, 4'd0);
    out_ready_i = 0;
    step();
    in_valid_i = 0;
    #1 rst = 1;
    #1;
    check("midrst_valid", out_valid_o, 0);
    check("midrst_ready", in_ready_o, 1);
    check("midrst_ops", {op1_o, op2_o, f3_o, f7_o, rd_o, rd_we_o}, 0);
    step();
    rst = 0;
    step();
    check("post_rst_valid", out_valid_o, 0);
    for (int c = 0; c < 500; c++) begin
      randomize_inputs();
      step();
    end
    in_valid_i = 0; flush_i = 0; out_ready_i = 1;
    step(); step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
